// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX path and, later, by the TX path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    localparam int DATA_BITS = 8;
    localparam int MIN_DIV   = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO; pointers carry one extra wrap bit.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// small receive FIFO with sticky frame/overrun (and parity) error flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             rd_en,
    input  logic             err_clr,
    output logic [7:0]       rd_data,
    output logic             rx_valid,
    output logic [CNT_W-1:0] fifo_count,
    output logic             frame_err,
    output logic             overrun_err
`ifdef UART_RX_PARITY_EN
    ,output logic            parity_err
`endif
);

    logic             sync0;
    logic             rxs;
    uart_state_e      state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [DIV_W-1:0] div_eff;
    logic [2:0]       idx, idx_n;
    logic [7:0]       shift, shift_n;
    logic             tick0;
    logic             push_req;
    logic             set_fe;
    logic             set_oe;
    logic             pop_ok;
    logic             fifo_full;
    logic             fifo_empty;
`ifdef UART_RX_PARITY_EN
    logic             par_bad, par_bad_n;
    logic             set_pe;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync0 <= rx;
            rxs   <= sync0;
        end
    end

    assign div_eff = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
    assign tick0   = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            div_q   <= DIV_W'(MIN_DIV);
            idx     <= '0;
            shift   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_q   <= div_n;
            idx     <= idx_n;
            shift   <= shift_n;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        div_n    = div_q;
        idx_n    = idx;
        shift_n  = shift;
        push_req = 1'b0;
        set_fe   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        set_pe    = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Divisor is captured here so mid-frame changes are ignored.
                if (!rxs) begin
                    state_n = START;
                    div_n   = div_eff;
                    cnt_n   = (div_eff >> 1) - DIV_W'(1);
                end
            end
            START: begin
                if (tick0) begin
                    if (rxs) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        cnt_n   = div_q - DIV_W'(1);
                        idx_n   = '0;
                    end
                end else begin
                    cnt_n = cnt - DIV_W'(1);
                end
            end
            DATA: begin
                if (tick0) begin
                    shift_n[idx] = rxs;
                    cnt_n        = div_q - DIV_W'(1);
                    if (idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt - DIV_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick0) begin
                    par_bad_n = (^shift) ^ rxs;
                    set_pe    = (^shift) ^ rxs;
                    cnt_n     = div_q - DIV_W'(1);
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt - DIV_W'(1);
                end
            end
`endif
            STOP: begin
                if (tick0) begin
                    if (rxs) begin
`ifdef UART_RX_PARITY_EN
                        push_req = ~par_bad;
`else
                        push_req = 1'b1;
`endif
                        state_n  = IDLE;
                    end else begin
                        set_fe  = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    cnt_n = cnt - DIV_W'(1);
                end
            end
            BREAK: begin
                // Hold off start detection until the line returns high.
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign pop_ok = rd_en & ~fifo_empty;
    assign set_oe = push_req & fifo_full & ~pop_ok;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (rd_en),
        .din   (shift),
        .dout  (rd_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx_valid = ~fifo_empty;

    // Set takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            frame_err   <= set_fe | (frame_err & ~err_clr);
            overrun_err <= set_oe | (overrun_err & ~err_clr);
`ifdef UART_RX_PARITY_EN
            parity_err  <= set_pe | (parity_err & ~err_clr);
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard; honours UART_RX_PARITY_EN.
module tb_uart_rx_fifo;

    localparam int DIV_W      = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             rx;
    logic [DIV_W-1:0] baud_div;
    logic             rd_en;
    logic             err_clr;
    logic [7:0]       rd_data;
    logic             rx_valid;
    logic [CNT_W-1:0] fifo_count;
    logic             frame_err;
    logic             overrun_err;
`ifdef UART_RX_PARITY_EN
    logic             parity_err;
`endif

    int         checks   = 0;
    int         failures = 0;
    int         per      = 16;
    logic [7:0] sb[$];
    logic       exp_ovr  = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DIV_W      (DIV_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .baud_div    (baud_div),
        .rd_en       (rd_en),
        .err_clr     (err_clr),
        .rd_data     (rd_data),
        .rx_valid    (rx_valid),
        .fifo_count  (fifo_count),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
`ifdef UART_RX_PARITY_EN
        ,.parity_err (parity_err)
`endif
    );

    // Returns 1 ns after a rising edge so every drive and sample is clear of it.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pop_stop raises rd_en on the stop-bit sample edge (valid for per=16).
    task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                              input logic pop_stop, input logic par_flip);
        rx = 1'b0;
        tick(per);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(per);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        tick(per);
`else
        if (par_flip) rx = 1'b1;
`endif
        rx = stop_ok;
        for (int k = 1; k <= per; k++) begin
            rd_en = pop_stop && (k == 11);
            tick(1);
        end
        rd_en = 1'b0;
        if (stop_ok) rx = 1'b1;
        tick(4);
    endtask

    task automatic send_good(input logic [7:0] d);
        if (sb.size() < FIFO_DEPTH) sb.push_back(d);
        else exp_ovr = 1'b1;
        send_frame(d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = sb.pop_front();
        check(tag, rd_data, e);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        baud_div = 16;
        rd_en    = 1'b0;
        err_clr  = 1'b0;
        tick(5);
        check("rst_valid", rx_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_data", rd_data, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_oerr", overrun_err, 0);
        rst = 1'b0;
        tick(3);

        // basic reception and first-word fall-through
        send_good(8'hA5);
        check("b1_valid", rx_valid, 1);
        check("b1_data", rd_data, sb[0]);
        check("b1_count", fifo_count, 32'(sb.size()));
        send_good(8'h5A);
        check("b2_count", fifo_count, 32'(sb.size()));
        pop_check("b_pop1");
        check("b_head", rd_data, 8'h5A);
        check("b_count1", fifo_count, 32'(sb.size()));
        pop_check("b_pop2");
        check("b_empty_data", rd_data, 0);

        // glitch shorter than half a bit
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(200);
        check("gl_count", fifo_count, 0);
        check("gl_ferr", frame_err, 0);
        check("gl_oerr", overrun_err, 0);

        // framing error followed by a held-low line
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        tick(40);
        check("fe_flag_low", frame_err, 1);
        rx = 1'b1;
        tick(200);
        check("fe_count", fifo_count, 0);
        check("fe_flag", frame_err, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("fe_clr", frame_err, 0);

        // overrun and pointer wrap
        for (int b = 1; b <= 9; b++) send_good(8'(b));
        check("ov_count", fifo_count, 32'(FIFO_DEPTH));
        check("ov_flag", overrun_err, exp_ovr);
        for (int b = 1; b <= 8; b++) pop_check("ov_pop");
        check("ov_drained", fifo_count, 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        exp_ovr = 1'b0;
        check("ov_clr", overrun_err, 0);
        send_good(8'h0A);
        check("wrap_data", rd_data, 8'h0A);
        pop_check("wrap_pop");

        // full FIFO with a pop on the stop-sample edge of a ninth byte
        for (int b = 0; b < 8; b++) send_good(8'h20 + 8'(b));
        check("fp_full", fifo_count, 8);
        check("fp_head", rd_data, sb[0]);
        void'(sb.pop_front());
        sb.push_back(8'h28);
        send_frame(8'h28, 1'b1, 1'b1, 1'b0);
        check("fp_oerr", overrun_err, 0);
        check("fp_count", fifo_count, 8);
        for (int b = 0; b < 8; b++) pop_check("fp_pop");

        // minimum divisor clamp
        baud_div = 2;
        per      = 4;
        send_good(8'h96);
        check("div_count", fifo_count, 1);
        pop_check("div_pop");
        baud_div = 16;
        per      = 16;

        // reset mid-frame with bytes queued and a flag set
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        rx = 1'b1;
        tick(20);
        for (int b = 0; b < 3; b++) send_good(8'h31 + 8'(b));
        check("rm_pre_count", fifo_count, 3);
        rx = 1'b0;
        tick(per);
        rx = 1'b1;
        tick(per * 4 + 8);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        sb.delete();
        tick(2);
        check("rm_count", fifo_count, 0);
        check("rm_valid", rx_valid, 0);
        check("rm_ferr", frame_err, 0);
        check("rm_oerr", overrun_err, 0);
        tick(200);
        send_good(8'h11);
        check("rm_count_after", fifo_count, 1);
        pop_check("rm_data");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        check("par_flag", parity_err, 1);
        check("par_count", fifo_count, 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("par_clr", parity_err, 0);
        send_good(8'h07);
        check("par_good_flag", parity_err, 0);
        pop_check("par_good_data");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
